mult_div: RTL and testbench
===========================

MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have `clock`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have `start_mult`, input, 1 bit: requests a signed multiply of a by b.
REQ-004 SHALL have `start_div`, input, 1 bit: requests a signed divide of a by b.
REQ-005 SHALL have `a`, input, 32 bits: multiplicand or dividend, sampled at the accepting edge only.
REQ-006 SHALL have `b`, input, 32 bits: multiplier or divisor, sampled at the accepting edge only.
REQ-007 SHALL have `hi`, output, 32 bits: product[63:32] or remainder.
REQ-008 SHALL have `lo`, output, 32 bits: product[31:0] or quotient.
REQ-009 SHALL have `busy`, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have `done`, output, 1 bit: single-cycle completion pulse.
REQ-011 SHALL have `div_zero`, output, 1 bit: divide-by-zero flag, valid only while done=1.

Function
REQ-012 SHALL implement the FSM states IDLE, MULT, DIV, FIX and DONE.
REQ-013 In IDLE, a start edge SHALL be accepted as follows:
- start_mult=1 with start_div=0: go to MULT.
- start_div=1 with start_mult=0: go to DIV.
- On acceptance: latch the magnitudes of a and b and both operand signs, and clear the 5-bit iteration counter.
REQ-014 Both starts high in IDLE SHALL be ignored: stay in IDLE, no outputs change.
REQ-015 Starts in any non-IDLE state SHALL be ignored, with no effect on the running operation.
REQ-016 MULT SHALL perform one unsigned shift-add step per cycle on the magnitudes, 32 steps, then go to FIX.
REQ-017 DIV SHALL perform one unsigned restoring shift-subtract step per cycle on the magnitudes, 32 steps, then go to FIX.
REQ-018 FIX SHALL apply sign correction, write hi/lo on that edge, and then go to DONE.
- Multiply: {hi,lo} = exact 64-bit two's-complement product.
- Divide: lo = quotient truncated toward zero; hi = remainder carrying the sign of a.
REQ-019 DONE SHALL assert done=1 for exactly one cycle and then go to IDLE.
REQ-020 Latency: if a start is accepted at edge N, done SHALL be high in the cycle following edge N+33.
REQ-021 hi/lo SHALL hold their values at all times except the FIX write edge, the div-by-zero edge (REQ-030) and reset.
- The operands are not read again after the accepting edge; changes to a/b mid-operation have no effect.
REQ-022 Boundary cases SHALL wrap modulo 2^32 with no trap:
- a=0x80000000, b=0xFFFFFFFF divide: lo=0x80000000, hi=0.
- 0x80000000 x 0x80000000: hi=0x40000000, lo=0.
REQ-023 A new start SHALL be accepted in the IDLE cycle immediately after DONE.

Reset
REQ-024 With reset=1 at an edge, the block SHALL go to IDLE from any state, including mid-operation.
REQ-025 That reset edge SHALL clear hi, lo, busy, done, div_zero, the counter and all internal datapath registers to 0.
REQ-026 Reset SHALL take priority over start inputs sampled at the same edge.
REQ-027 An operation interrupted by reset SHALL never produce done.

Configuration
REQ-028 SHALL use the macro MULT_DIV_DIV_ZERO_TRAP_EN.
REQ-029 With the macro defined, divide-by-zero SHALL be detected as follows:
- Condition: start_div accepted with b=0.
- Action: go directly from IDLE to DONE; do not enter DIV or FIX.
REQ-030 With the macro defined, a trapped divide-by-zero SHALL produce:
- done=1 and div_zero=1 in the cycle following the accepting edge (latency 1).
- hi and lo unchanged.
REQ-031 With the macro undefined, divide-by-zero SHALL run the normal 33-edge path:
- Result: lo=0xFFFFFFFF, hi=a.
- div_zero tied to 0.

Verification
REQ-032 Scenario: start_mult, a=7, b=0xFFFFFFFD -> done 33 edges later, hi=0xFFFFFFFF, lo=0xFFFFFFEB, div_zero=0.
REQ-033 Scenario: start_div, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, done 33 edges after acceptance.
REQ-034 Scenario: start_div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; then start_mult a=b=0x80000000 -> hi=0x40000000, lo=0.
REQ-035 Scenario: start_div, b=0, a=5, prior hi/lo=0x11/0x22:
- Macro defined: done=div_zero=1 one cycle later, hi/lo remain 0x11/0x22.
- Macro undefined: after 33 edges, lo=0xFFFFFFFF, hi=5, div_zero=0.
REQ-036 Scenario: start_mult 3x4, pulse start_div at cycle 10, change a at cycle 12 -> result still hi=0, lo=12, exactly one done pulse.
REQ-037 Scenario: start_mult, then assert reset at cycle 20 -> next cycle busy=0, hi=lo=0, no done; a new start_mult 2x2 is then accepted and gives lo=4.

Source files
------------

// File: rtl/mult_div.sv
// ---------------------------------------------------------------------------
// mult_div : iterative 32-bit signed multiplier / divider
//
// Runs one shift-add (multiply) or restoring shift-subtract (divide) step per
// clock on operand magnitudes. Signs are applied once, in the FIX state.
// A start accepted at edge N gives done=1 in the cycle after edge N+33.
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start_mult/start_div: operation requests, honoured only in IDLE and only
//                         when exactly one of them is high
//   a, b                : operands, sampled on the accepting edge only
//   hi, lo              : product[63:32]/[31:0] or remainder/quotient
//   busy                : high in every state except IDLE
//   done                : one-cycle completion pulse
//   div_zero            : divide-by-zero flag, meaningful while done=1
//
// Build option
//   MULT_DIV_DIV_ZERO_TRAP_EN : when defined, a divide by zero finishes
//   immediately (IDLE -> DONE) with div_zero=1 and hi/lo untouched. When
//   undefined it runs the normal path (lo=all ones, hi=a) and div_zero=0.
// ---------------------------------------------------------------------------
module mult_div (
   input  logic        clock,
   input  logic        reset,
   input  logic        start_mult,
   input  logic        start_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;   // mult: {partial, multiplier}; div: {rem, quot}
   logic [31:0] opnd_q, opnd_d;   // mult: |a|; div: |b|
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic        is_div_q, is_div_d;
   logic        bz_q, bz_d;       // divisor was zero
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
   logic        dz_q, dz_d;
`endif

   logic        accept;
   logic [31:0] a_mag, b_mag;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shl;
   logic [33:0] div_diff;
   logic [63:0] div_next;
   logic [63:0] prod_neg;
   logic [31:0] quot_neg, rem_neg;

   assign accept = (state_q == IDLE) && (start_mult ^ start_div);
   assign a_mag  = a[31] ? (~a + 32'd1) : a;
   assign b_mag  = b[31] ? (~b + 32'd1) : b;

   // Multiply step: add multiplicand into upper half when multiplier lsb set,
   // then shift the whole 65-bit result right by one.
   assign mul_sum  = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, prod_q[31:1]};

   // Divide step: shift next dividend bit into the remainder and try to
   // subtract. Extra guard bit keeps a zero divisor from looking negative.
   assign div_shl  = {prod_q[63:32], prod_q[31]};
   assign div_diff = {1'b0, div_shl} - {2'b00, opnd_q};
   assign div_next = div_diff[33] ? {div_shl[31:0], prod_q[30:0], 1'b0}
                                  : {div_diff[31:0], prod_q[30:0], 1'b1};

   assign prod_neg = ~prod_q + 64'd1;
   assign quot_neg = ~prod_q[31:0] + 32'd1;
   assign rem_neg  = ~prod_q[63:32] + 32'd1;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         prod_q   <= '0;
         opnd_q   <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         is_div_q <= 1'b0;
         bz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
         dz_q     <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         opnd_q   <= opnd_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         is_div_q <= is_div_d;
         bz_q     <= bz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
         dz_q     <= dz_d;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_mult && !start_div) begin
               state_d = MULT;
            end else if (start_div && !start_mult) begin
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
               state_d = (b == 32'd0) ? DONE : DIV;
`else
               state_d = DIV;
`endif
            end
         end
         MULT:    if (cnt_q == 5'd31) state_d = FIX;
         DIV:     if (cnt_q == 5'd31) state_d = FIX;
         FIX:     state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath next-state
   always_comb begin
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      opnd_d   = opnd_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      is_div_d = is_div_q;
      bz_d     = bz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
      dz_d     = dz_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d    = '0;
               sa_d     = a[31];
               sb_d     = b[31];
               is_div_d = start_div;
               bz_d     = (b == 32'd0);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
               dz_d     = start_div && (b == 32'd0);
`endif
               if (start_mult) begin
                  opnd_d = a_mag;
                  prod_d = {32'd0, b_mag};
               end else begin
                  opnd_d = b_mag;
                  prod_d = {32'd0, a_mag};
               end
            end
         end
         MULT: begin
            prod_d = mul_next;
            cnt_d  = cnt_q + 5'd1;
         end
         DIV: begin
            prod_d = div_next;
            cnt_d  = cnt_q + 5'd1;
         end
         FIX: begin
            if (is_div_q) begin
               // Zero divisor: quotient is all ones regardless of signs,
               // remainder (|a| with a's sign) reproduces a.
               lo_d = bz_q ? 32'hFFFF_FFFF : ((sa_q ^ sb_q) ? quot_neg : prod_q[31:0]);
               hi_d = sa_q ? rem_neg : prod_q[63:32];
            end else begin
               {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : prod_q;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
      div_zero = (state_q == DONE) && dz_q;
`else
      div_zero = 1'b0;
`endif
   end

   assign hi = hi_q;
   assign lo = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// ---------------------------------------------------------------------------
// tb_mult_div : self-checking bench for mult_div
// Reference results come from plain 64-bit signed arithmetic. Honours
// MULT_DIV_DIV_ZERO_TRAP_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_mult_div;

   logic        clock = 1'b0;
   logic        reset;
   logic        start_mult, start_div;
   logic [31:0] a, b;
   logic [31:0] hi, lo;
   logic        busy, done, div_zero;

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] exp_hi = 32'd0;
   logic [31:0] exp_lo = 32'd0;

   mult_div dut (
      .clock     (clock),
      .reset     (reset),
      .start_mult(start_mult),
      .start_div (start_div),
      .a         (a),
      .b         (b),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: signed arithmetic on 64-bit values. elat is the number of
   // edges after the accepting edge before done is seen.
   function automatic void model(input bit dv, input logic [31:0] aa, input logic [31:0] bb,
                                 inout logic [31:0] eh, inout logic [31:0] el,
                                 output bit edz, output int elat);
      longint sa, sb, p, q, r;
      sa   = longint'($signed(aa));
      sb   = longint'($signed(bb));
      edz  = 1'b0;
      elat = 33;
      if (!dv) begin
         p  = sa * sb;
         eh = p[63:32];
         el = p[31:0];
      end else if (bb == 32'd0) begin
`ifdef MULT_DIV_DIV_ZERO_TRAP_EN
         edz  = 1'b1;
         elat = 0;
`else
         el = 32'hFFFF_FFFF;
         eh = aa;
`endif
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         el = q[31:0];
         eh = r[31:0];
      end
   endfunction

   task automatic do_op(input bit dv, input logic [31:0] aa, input logic [31:0] bb, input string tag);
      logic [31:0] eh, el;
      bit          edz;
      int          elat, k;
      @(negedge clock);
      chk({tag, ":idle_busy"}, busy, 0);
      chk({tag, ":idle_done"}, done, 0);
      eh = exp_hi;
      el = exp_lo;
      model(dv, aa, bb, eh, el, edz, elat);
      a = aa; b = bb; start_mult = !dv; start_div = dv;
      @(negedge clock);
      start_mult = 1'b0; start_div = 1'b0;
      a = $urandom; b = $urandom;          // operands must not matter any more
      chk({tag, ":busy"}, busy, 1);
      k = 0;
      while (!done && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk({tag, ":latency"}, k, elat);
      chk({tag, ":hi"}, hi, eh);
      chk({tag, ":lo"}, lo, el);
      chk({tag, ":dz"}, div_zero, edz);
      exp_hi = eh;
      exp_lo = el;
   endtask

   logic [31:0] corner [5];

   initial begin
      int k, ndone;
      logic [31:0] ra, rb, h_cap, l_cap;
      corner[0] = 32'h0; corner[1] = 32'h1; corner[2] = 32'hFFFF_FFFF;
      corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;

      reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      chk("rst:hi", hi, 0);
      chk("rst:lo", lo, 0);
      chk("rst:busy", busy, 0);
      chk("rst:done", done, 0);
      chk("rst:dz", div_zero, 0);

      do_op(1'b0, 32'd7, 32'hFFFF_FFFD, "m7xm3");
      do_op(1'b1, 32'hFFFF_FFF9, 32'd2, "dm7by2");
      do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "dminby-1");
      do_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mminxmin");
      do_op(1'b1, 32'h451, 32'h20, "dprime");   // leaves hi=0x11, lo=0x22
      do_op(1'b1, 32'd5, 32'd0, "d5by0");

      // Both starts together: ignored
      @(negedge clock);
      a = 32'd9; b = 32'd9; start_mult = 1'b1; start_div = 1'b1;
      @(negedge clock);
      start_mult = 1'b0; start_div = 1'b0;
      chk("both:busy", busy, 0);
      chk("both:hi", hi, exp_hi);
      chk("both:lo", lo, exp_lo);

      // Starts and operand changes during a running multiply
      @(negedge clock);
      a = 32'd3; b = 32'd4; start_mult = 1'b1;
      ndone = 0; h_cap = '0; l_cap = '0;
      for (int c = 1; c < 45; c++) begin
         @(negedge clock);
         start_mult = 1'b0;
         start_div  = (c == 10);
         if (c == 12) a = 32'd99;
         if (done) begin
            ndone++;
            h_cap = hi;
            l_cap = lo;
         end
      end
      chk("ignore:ndone", ndone, 1);
      chk("ignore:hi", h_cap, 0);
      chk("ignore:lo", l_cap, 12);
      exp_hi = 32'd0; exp_lo = 32'd12;

      // Reset in the middle of an operation
      a = 32'd6; b = 32'd7; start_mult = 1'b1;
      @(negedge clock);
      start_mult = 1'b0;
      repeat (19) @(negedge clock);
      reset = 1'b1; start_mult = 1'b1;      // reset wins over start
      @(negedge clock);
      reset = 1'b0; start_mult = 1'b0;
      chk("midrst:busy", busy, 0);
      chk("midrst:hi", hi, 0);
      chk("midrst:lo", lo, 0);
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clock);
         if (done) ndone++;
      end
      chk("midrst:nodone", ndone, 0);
      exp_hi = 32'd0; exp_lo = 32'd0;
      do_op(1'b0, 32'd2, 32'd2, "m2x2");

      // Randomized mix, back to back
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'd0;
         do_op(1'(($urandom_range(0, 1))), ra, rb, "rand");
      end

      k = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
